// File: rtl/alu_status_stage.sv
// alu_status_stage: registers the 6502 ALU result into the ADD hold register,
// keeps the processor status register P (N V - B D I Z C), supplies the
// pushed-P byte for PHP/BRK/IRQ, and tracks an IRQ mask that follows I
// with one instruction of lag.
module alu_status_stage #(
  parameter logic [7:0] P_RESET   = 8'h34,
  parameter logic [7:0] ADD_RESET = 8'h00
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] alu_result,
  input  logic       alu_cout,
  input  logic       alu_of,
  input  logic       alu_valid,
  input  logic       upd_nz,
  input  logic       upd_c,
  input  logic       upd_v,
  input  logic       upd_bit,
  input  logic [7:0] db_in,
  input  logic       p_load,
  input  logic       set_c,
  input  logic       clr_c,
  input  logic       set_i,
  input  logic       clr_i,
  input  logic       set_d,
  input  logic       clr_d,
  input  logic       clr_v,
  input  logic       int_entry,
  input  logic       hw_int,
  input  logic       sync,
  output logic [7:0] add_reg,
  output logic [7:0] p_out,
  output logic [7:0] push_val,
  output logic       carry_flag,
  output logic       dec_flag,
  output logic       irq_mask
);

  // Stored flags; bits 5 and 4 of P are not stored, only reconstructed.
  logic [7:0] add_q, add_d;
  logic       n_q, n_d;
  logic       v_q, v_d;
  logic       d_q, d_d;
  logic       i_q, i_d;
  logic       z_q, z_d;
  logic       c_q, c_d;
  logic       irq_mask_q, irq_mask_d;

  logic       res_zero_s;
  logic       bit_en_s;
  logic       nz_en_s;
  logic       c_en_s;
  logic       v_en_s;

  assign res_zero_s = (alu_result == 8'h00);
  // ALU-sourced updates only count when the ALU result is valid.
  assign bit_en_s   = alu_valid & upd_bit;
  assign nz_en_s    = alu_valid & upd_nz;
  assign c_en_s     = alu_valid & upd_c;
  assign v_en_s     = alu_valid & upd_v;

  // Next-state for ADD and every stored flag, highest priority source first.
  always_comb begin
    add_d      = add_q;
    n_d        = n_q;
    v_d        = v_q;
    d_d        = d_q;
    i_d        = i_q;
    z_d        = z_q;
    c_d        = c_q;
    irq_mask_d = irq_mask_q;

    if (alu_valid) begin
      add_d = alu_result;
    end else begin
      add_d = add_q;
    end

    // N: PLP/RTI, then BIT operand bit 7, then result sign.
    if (p_load) begin
      n_d = db_in[7];
    end else if (bit_en_s) begin
      n_d = db_in[7];
    end else if (nz_en_s) begin
      n_d = alu_result[7];
    end else begin
      n_d = n_q;
    end

    // V: PLP/RTI, CLV, BIT operand bit 6, then ALU overflow.
    if (p_load) begin
      v_d = db_in[6];
    end else if (clr_v) begin
      v_d = 1'b0;
    end else if (bit_en_s) begin
      v_d = db_in[6];
    end else if (v_en_s) begin
      v_d = alu_of;
    end else begin
      v_d = v_q;
    end

    // D: PLP/RTI, then SED/CLD; a simultaneous set and clear holds.
    if (p_load) begin
      d_d = db_in[3];
    end else if (set_d && clr_d) begin
      d_d = d_q;
    end else if (set_d) begin
      d_d = 1'b1;
    end else if (clr_d) begin
      d_d = 1'b0;
    end else begin
      d_d = d_q;
    end

    // I: interrupt entry dominates, then PLP/RTI, then SEI/CLI.
    if (int_entry) begin
      i_d = 1'b1;
    end else if (p_load) begin
      i_d = db_in[2];
    end else if (set_i && clr_i) begin
      i_d = i_q;
    end else if (set_i) begin
      i_d = 1'b1;
    end else if (clr_i) begin
      i_d = 1'b0;
    end else begin
      i_d = i_q;
    end

    // Z: PLP/RTI, then BIT/ALU zero test (same source for both).
    if (p_load) begin
      z_d = db_in[1];
    end else if (bit_en_s || nz_en_s) begin
      z_d = res_zero_s;
    end else begin
      z_d = z_q;
    end

    // C: PLP/RTI, then SEC/CLC, then ALU carry out.
    if (p_load) begin
      c_d = db_in[0];
    end else if (set_c && clr_c) begin
      c_d = c_q;
    end else if (set_c) begin
      c_d = 1'b1;
    end else if (clr_c) begin
      c_d = 1'b0;
    end else if (c_en_s) begin
      c_d = alu_cout;
    end else begin
      c_d = c_q;
    end

    // The mask samples the pre-edge I at each opcode fetch, so CLI/SEI/PLP
    // take effect one instruction late; interrupt entry masks immediately.
    if (int_entry) begin
      irq_mask_d = 1'b1;
    end else if (sync) begin
      irq_mask_d = i_q;
    end else begin
      irq_mask_d = irq_mask_q;
    end
  end

  // State register with synchronous reset overriding every other input.
  always_ff @(posedge clk) begin
    if (rst) begin
      add_q      <= ADD_RESET;
      n_q        <= P_RESET[7];
      v_q        <= P_RESET[6];
      d_q        <= P_RESET[3];
      i_q        <= P_RESET[2];
      z_q        <= P_RESET[1];
      c_q        <= P_RESET[0];
      irq_mask_q <= 1'b1;
    end else begin
      add_q      <= add_d;
      n_q        <= n_d;
      v_q        <= v_d;
      d_q        <= d_d;
      i_q        <= i_d;
      z_q        <= z_d;
      c_q        <= c_d;
      irq_mask_q <= irq_mask_d;
    end
  end

  assign add_reg    = add_q;
  assign p_out      = {n_q, v_q, 1'b1, 1'b1, d_q, i_q, z_q, c_q};
  // Pushed B bit is 1 for PHP/BRK and 0 for hardware interrupts.
  assign push_val   = {n_q, v_q, 1'b1, ~hw_int, d_q, i_q, z_q, c_q};
  assign carry_flag = c_q;
  assign dec_flag   = d_q;
  assign irq_mask   = irq_mask_q;

endmodule

// File: tb/tb_alu_status_stage.sv
// Scoreboard bench for alu_status_stage: the driver issues directed vectors
// and queues hand-computed results; a monitor checks them after each edge.
module tb_alu_status_stage;

  logic       clk;
  logic       rst;
  logic [7:0] alu_result;
  logic       alu_cout;
  logic       alu_of;
  logic       alu_valid;
  logic       upd_nz;
  logic       upd_c;
  logic       upd_v;
  logic       upd_bit;
  logic [7:0] db_in;
  logic       p_load;
  logic       set_c;
  logic       clr_c;
  logic       set_i;
  logic       clr_i;
  logic       set_d;
  logic       clr_d;
  logic       clr_v;
  logic       int_entry;
  logic       hw_int;
  logic       sync;
  logic [7:0] add_reg;
  logic [7:0] p_out;
  logic [7:0] push_val;
  logic       carry_flag;
  logic       dec_flag;
  logic       irq_mask;

  typedef struct {
    string      name;
    logic [7:0] add;
    logic [7:0] p;
    logic [7:0] push;
    logic       mask;
  } exp_t;

  exp_t sb_q[$];
  int   checks;
  int   errors;

  alu_status_stage dut (
    .clk(clk), .rst(rst), .alu_result(alu_result), .alu_cout(alu_cout),
    .alu_of(alu_of), .alu_valid(alu_valid), .upd_nz(upd_nz), .upd_c(upd_c),
    .upd_v(upd_v), .upd_bit(upd_bit), .db_in(db_in), .p_load(p_load),
    .set_c(set_c), .clr_c(clr_c), .set_i(set_i), .clr_i(clr_i),
    .set_d(set_d), .clr_d(clr_d), .clr_v(clr_v), .int_entry(int_entry),
    .hw_int(hw_int), .sync(sync), .add_reg(add_reg), .p_out(p_out),
    .push_val(push_val), .carry_flag(carry_flag), .dec_flag(dec_flag),
    .irq_mask(irq_mask)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Simultaneous set and clear of the same flag is illegal stimulus.
  always @(posedge clk) begin
    if (!rst) begin
      assert (!(set_c && clr_c) && !(set_i && clr_i) && !(set_d && clr_d))
        else $error("illegal set/clr conflict");
    end
  end

  task automatic cmp(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %02h expected %02h", nm, act, exp);
    end
  endtask

  // Monitor: one queued expectation is consumed just after every active edge.
  always @(posedge clk) begin
    #1;
    if (sb_q.size() > 0) begin
      exp_t e;
      e = sb_q.pop_front();
      cmp({e.name, ".add_reg"},    add_reg,           e.add);
      cmp({e.name, ".p_out"},      p_out,             e.p);
      cmp({e.name, ".push_val"},   push_val,          e.push);
      cmp({e.name, ".irq_mask"},   {7'd0, irq_mask},  {7'd0, e.mask});
      cmp({e.name, ".carry_flag"}, {7'd0, carry_flag}, {7'd0, e.p[0]});
      cmp({e.name, ".dec_flag"},   {7'd0, dec_flag},  {7'd0, e.p[3]});
    end
  end

  task automatic clr_in();
    rst = 1'b0; alu_result = 8'h00; alu_cout = 1'b0; alu_of = 1'b0;
    alu_valid = 1'b0; upd_nz = 1'b0; upd_c = 1'b0; upd_v = 1'b0;
    upd_bit = 1'b0; db_in = 8'h00; p_load = 1'b0; set_c = 1'b0;
    clr_c = 1'b0; set_i = 1'b0; clr_i = 1'b0; set_d = 1'b0; clr_d = 1'b0;
    clr_v = 1'b0; int_entry = 1'b0; hw_int = 1'b0; sync = 1'b0;
  endtask

  // Queue the result expected after the coming edge, then move to the next cycle.
  task automatic go(input string nm, input logic [7:0] a, input logic [7:0] p,
                    input logic m, input logic [7:0] pu);
    exp_t e;
    e.name = nm; e.add = a; e.p = p; e.mask = m; e.push = pu;
    sb_q.push_back(e);
    @(negedge clk);
    clr_in();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    clr_in();
    rst = 1'b1;
    @(negedge clk);
    clr_in();

    rst = 1'b1;
    go("reset", 8'h00, 8'h34, 1'b1, 8'h34);

    alu_valid = 1'b1; alu_result = 8'h80; alu_cout = 1'b1; alu_of = 1'b1;
    upd_nz = 1'b1; upd_c = 1'b1; upd_v = 1'b1;
    go("nzcv", 8'h80, 8'hF5, 1'b1, 8'hF5);

    alu_valid = 1'b1; alu_result = 8'h00; upd_nz = 1'b1; set_c = 1'b1;
    go("zero_sec", 8'h00, 8'h77, 1'b1, 8'h77);

    alu_valid = 1'b0; alu_result = 8'h55; upd_nz = 1'b1;
    go("invalid_hold", 8'h00, 8'h77, 1'b1, 8'h77);

    p_load = 1'b1; db_in = 8'hCB; clr_c = 1'b1;
    go("plp", 8'h00, 8'hFB, 1'b1, 8'hFB);

    hw_int = 1'b1;
    go("push_hw", 8'h00, 8'hFB, 1'b1, 8'hEB);

    set_i = 1'b1;
    go("sei", 8'h00, 8'hFF, 1'b1, 8'hFF);
    clr_i = 1'b1;
    go("cli", 8'h00, 8'hFB, 1'b1, 8'hFB);
    go("cli_wait1", 8'h00, 8'hFB, 1'b1, 8'hFB);
    go("cli_wait2", 8'h00, 8'hFB, 1'b1, 8'hFB);
    sync = 1'b1;
    go("sync1", 8'h00, 8'hFB, 1'b0, 8'hFB);
    go("nosync_hold", 8'h00, 8'hFB, 1'b0, 8'hFB);
    sync = 1'b1;
    go("sync2", 8'h00, 8'hFB, 1'b0, 8'hFB);
    set_i = 1'b1; sync = 1'b1;
    go("sei_sync_lag", 8'h00, 8'hFF, 1'b0, 8'hFF);
    sync = 1'b1;
    go("sync3", 8'h00, 8'hFF, 1'b1, 8'hFF);
    clr_i = 1'b1;
    go("cli2", 8'h00, 8'hFB, 1'b1, 8'hFB);
    sync = 1'b1;
    go("sync4", 8'h00, 8'hFB, 1'b0, 8'hFB);
    int_entry = 1'b1; clr_i = 1'b1;
    go("int_entry", 8'h00, 8'hFF, 1'b1, 8'hFF);

    upd_bit = 1'b1; alu_valid = 1'b1; db_in = 8'h40; alu_result = 8'h00;
    upd_nz = 1'b1;
    go("bit_40", 8'h00, 8'h7F, 1'b1, 8'h7F);

    upd_bit = 1'b1; upd_v = 1'b1; upd_c = 1'b1; alu_valid = 1'b1;
    db_in = 8'h80; alu_result = 8'h05; alu_of = 1'b1; alu_cout = 1'b0;
    go("bit_80_c", 8'h05, 8'hBC, 1'b1, 8'hBC);

    clr_d = 1'b1; clr_v = 1'b1; alu_valid = 1'b1; alu_result = 8'hFF;
    upd_nz = 1'b1; upd_c = 1'b1; upd_v = 1'b1; alu_of = 1'b1; alu_cout = 1'b1;
    go("cld_clv", 8'hFF, 8'hB5, 1'b1, 8'hB5);

    set_d = 1'b1; hw_int = 1'b1;
    go("sed", 8'hFF, 8'hBD, 1'b1, 8'hAD);

    rst = 1'b1; p_load = 1'b1; db_in = 8'h00; alu_valid = 1'b1;
    alu_result = 8'h99;
    go("rst_over_plp", 8'h00, 8'h34, 1'b1, 8'h34);

    @(negedge clk);
    @(negedge clk);
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", sb_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Hard time limit in case the run stalls.
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/alu_status_stage.md
Name: alu_status_stage

Overview:
- Stage directly downstream of the 6502 ALU.
- Registers the ALU result into the ADD hold register.
- Derives N/Z/C/V from the ALU outputs and maintains the processor status register P, including the D flag that drives ALU DEC_En and the C flag that drives ALU Cin.
- Also provides the pushed-P value for PHP/BRK/IRQ, and a CPU-visible IRQ mask that applies I-flag changes at instruction boundaries.

Parameters:
- P_RESET, 8'h34, reset value of P (I=1, bits 5 and 4 read as 1, all other flags 0).
- ADD_RESET, 8'h00, reset value of the ADD hold register.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-high reset.
- alu_result  input  8  ALU RESULT.
- alu_cout  input  1  ALU carry out (binary or BCD, as selected by the ALU).
- alu_of  input  1  ALU overflow.
- alu_valid  input  1  capture alu_result into ADD this cycle.
- upd_nz  input  1  update N and Z from alu_result (qualified by alu_valid).
- upd_c  input  1  update C from alu_cout (qualified by alu_valid).
- upd_v  input  1  update V from alu_of (qualified by alu_valid).
- upd_bit  input  1  BIT: N<=db_in[7], V<=db_in[6], Z<=(alu_result==0) (qualified by alu_valid).
- db_in  input  8  data bus (PLP/RTI source, BIT operand).
- p_load  input  1  load P from db_in (PLP/RTI).
- set_c, clr_c, set_i, clr_i, set_d, clr_d, clr_v  input  1 each  explicit flag instructions.
- int_entry  input  1  interrupt/BRK entry: forces I=1 and irq_mask=1.
- hw_int  input  1  selects the pushed B bit: 0 for PHP/BRK, 1 for IRQ/NMI.
- sync  input  1  instruction boundary (opcode fetch cycle).
- add_reg  output  8  registered ALU result.
- p_out  output  8  P with bits 5 and 4 forced to 1.
- push_val  output  8  P with bit5=1 and bit4=~hw_int.
- carry_flag  output  1  P[0], drives ALU Cin.
- dec_flag  output  1  P[3], drives ALU DEC_En.
- irq_mask  output  1  effective IRQ mask.

Behaviour:
- P bit layout: N7 V6 -5 B4 D3 I2 Z1 C0. Bits 5 and 4 are not stored; they are reconstructed on every read output.
- Reset (rst=1 at edge):
  - P=P_RESET, add_reg=ADD_RESET, irq_mask=1.
  - Overrides all other inputs, including mid-operation.
- ADD capture: if alu_valid=1, add_reg<=alu_result. Latency is one cycle. ADD holds when alu_valid=0.
- Flag updates take effect one cycle after the strobe. Priority per flag, highest first:
  1. rst
  2. int_entry (I only)
  3. p_load (all stored flags from db_in; db_in bits 5 and 4 are ignored)
  4. explicit set/clr
  5. upd_bit
  6. upd_nz / upd_c / upd_v
  7. hold
- Set/clear conflicts: set_x and clr_x asserted together means flag x holds. A bench assertion flags this as illegal.
- Flag derivation:
  - Z = (alu_result==8'h00).
  - N = alu_result[7].
  - C = alu_cout.
  - V = alu_of.
  - The upd_* and upd_bit inputs are ignored when alu_valid=0.
- upd_bit together with upd_nz or upd_v: upd_bit wins for N, V and Z. upd_c still applies.
- irq_mask:
  - int_entry sets it to 1 in the same edge as I.
  - Otherwise, on an edge with sync=1, irq_mask <= I value before that edge (the pre-edge P[2]).
  - Effect: CLI/SEI/PLP changes reach the mask one instruction later.
  - When sync=0, irq_mask holds.
- Outputs carry_flag and dec_flag reflect registered P. They have no combinational path from the inputs.
- push_val is combinational from registered P and hw_int.

Test Plan:
- rst 1 cycle -> p_out=8'h34, add_reg=8'h00, irq_mask=1, carry_flag=0, dec_flag=0.
- alu_valid=1, alu_result=8'h80, alu_cout=1, alu_of=1, upd_nz=upd_c=upd_v=1 -> next cycle add_reg=8'h80, p_out=8'hF5.
- alu_valid=1, alu_result=8'h00, upd_nz=1 with set_c=1 in the same cycle -> Z=1, N=0, C=1; then alu_valid=0 with upd_nz=1 and alu_result=8'h55 -> P and add_reg unchanged.
- p_load=1, db_in=8'hCB, with clr_c=1 in the same cycle -> p_out=8'hFB (p_load wins, bits 5 and 4 forced); push_val=8'hFB with hw_int=0 and 8'hEB with hw_int=1.
- clr_i at cycle t, sync pulses at t+3 and t+6 -> I=0 at t+1; irq_mask stays 1 until the t+3 edge, then reads 0. int_entry at t+8 -> I=1 and irq_mask=1 at t+9 without sync.
- upd_bit=1, alu_valid=1, db_in=8'h40, alu_result=8'h00, upd_nz=1 -> N=0, V=1, Z=1. Assert rst during a p_load cycle -> P=8'h34.
